// File: rtl/jump_target_table.sv
// Programmable jump-target table: entries hold absolute or PC-relative targets,
// loaded at run time, lookups resolve one cycle later with valid/fault flags.
module jump_target_table #(
   parameter int PTR_W  = 5,
   parameter int ADDR_W = 12
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Flush,
   input  logic              WrEn,
   input  logic [PTR_W-1:0]  WrPtr,
   input  logic [ADDR_W-1:0] WrData,
   input  logic              WrRel,
   input  logic              LookupReq,
   input  logic [PTR_W-1:0]  Jptr,
   input  logic [ADDR_W-1:0] Pc,
   output logic [ADDR_W-1:0] Jump,
   output logic              JumpValid,
   output logic              JumpFault,
   output logic              Ready,
   output logic              DbgState
);

   localparam int DEPTH = 2 ** PTR_W;

   localparam logic ST_INIT = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   // Handshake: there is no backpressure. WrEn/LookupReq are single-cycle strobes
   // taken on any rising edge where Ready=1 and Flush=0; JumpValid is a one-cycle
   // pulse that marks Jump/JumpFault as new, and it has no ready.

   logic                state;
   logic [PTR_W-1:0]    sweep_cnt;
   logic [DEPTH-1:0]    valid_q;
   logic [DEPTH-1:0]    rel_q;
   logic [ADDR_W-1:0]   data_q [DEPTH];

   logic                run_ok;
   logic                wr_fire;
   logic                bypass;
   logic                hit_valid;
   logic                hit_rel;
   logic [ADDR_W-1:0]   hit_data;
   logic [ADDR_W-1:0]   resolved;

   assign run_ok  = (state == ST_RUN) && !Flush;
   assign wr_fire = run_ok && WrEn;

   // Write-first bypass: a same-index write in the lookup cycle wins over storage.
   assign bypass    = WrEn && (WrPtr == Jptr);
   assign hit_valid = bypass ? 1'b1   : valid_q[Jptr];
   assign hit_rel   = bypass ? WrRel  : rel_q[Jptr];
   assign hit_data  = bypass ? WrData : data_q[Jptr];
   assign resolved  = hit_rel ? (Pc + hit_data) : hit_data;

   assign Ready    = (state == ST_RUN);
   assign DbgState = state;

   // Table contents have no reset; only the valid bits are cleared, by the sweep.
   always_ff @(posedge Clk) begin
      if (state == ST_INIT) begin
         valid_q[sweep_cnt] <= 1'b0;
      end else if (wr_fire) begin
         valid_q[WrPtr] <= 1'b1;
         rel_q[WrPtr]   <= WrRel;
         data_q[WrPtr]  <= WrData;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= ST_INIT;
         sweep_cnt <= '0;
         Jump      <= '0;
         JumpValid <= 1'b0;
         JumpFault <= 1'b0;
      end else begin
         JumpValid <= 1'b0;
         if (state == ST_INIT) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == PTR_W'(DEPTH - 1)) begin
               state <= ST_RUN;
            end
         end else if (Flush) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
         end else if (LookupReq) begin
            JumpValid <= 1'b1;
            JumpFault <= !hit_valid;
            Jump      <= hit_valid ? resolved : '0;
         end
      end
   end

endmodule

// File: tb/tb_jump_target_table.sv
// Directed bench for jump_target_table: init sweep, abs/rel lookups, bypass,
// flush and mid-sweep reset, each against hand-computed values.
module tb_jump_target_table;

   localparam int PTR_W  = 5;
   localparam int ADDR_W = 12;

   logic              Clk;
   logic              Reset_n;
   logic              Flush;
   logic              WrEn;
   logic [PTR_W-1:0]  WrPtr;
   logic [ADDR_W-1:0] WrData;
   logic              WrRel;
   logic              LookupReq;
   logic [PTR_W-1:0]  Jptr;
   logic [ADDR_W-1:0] Pc;
   logic [ADDR_W-1:0] Jump;
   logic              JumpValid;
   logic              JumpFault;
   logic              Ready;
   logic              DbgState;

   int n_checks = 0;
   int n_errors = 0;

   jump_target_table #(.PTR_W(PTR_W), .ADDR_W(ADDR_W)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .WrEn(WrEn), .WrPtr(WrPtr),
      .WrData(WrData), .WrRel(WrRel), .LookupReq(LookupReq), .Jptr(Jptr), .Pc(Pc),
      .Jump(Jump), .JumpValid(JumpValid), .JumpFault(JumpFault), .Ready(Ready),
      .DbgState(DbgState)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      Flush = 0; WrEn = 0; WrPtr = '0; WrData = '0; WrRel = 0;
      LookupReq = 0; Jptr = '0; Pc = '0;
   endtask

   task automatic do_write(input int ptr, input int data, input bit rel);
      WrEn = 1; WrPtr = PTR_W'(ptr); WrData = ADDR_W'(data); WrRel = rel;
      tick();
      WrEn = 0;
   endtask

   task automatic do_lookup(input int ptr, input int pc);
      LookupReq = 1; Jptr = PTR_W'(ptr); Pc = ADDR_W'(pc);
      tick();
      LookupReq = 0;
   endtask

   // after the flush/reset edge, expect Ready low for 31 edges and high on the 32nd
   task automatic sweep_32(input string tag);
      for (int i = 1; i <= 32; i++) begin
         tick();
         check({tag, "_ready"}, Ready, (i == 32) ? 1 : 0);
         check({tag, "_jv"}, JumpValid, 0);
      end
   endtask

   initial begin
      idle_inputs();
      Reset_n = 0;
      tick();
      tick();
      check("rst_ready", Ready, 0);
      check("rst_jump", Jump, 0);
      check("rst_jv", JumpValid, 0);
      check("rst_jf", JumpFault, 0);

      // lookups held through the whole sweep must be ignored
      LookupReq = 1; Jptr = 5'd0;
      Reset_n = 1;
      sweep_32("init");
      LookupReq = 0;

      do_write(1, 9, 0);
      do_lookup(1, 0);
      check("abs_jump", Jump, 12'd9);
      check("abs_jv", JumpValid, 1);
      check("abs_jf", JumpFault, 0);
      tick();
      check("abs_jv_drop", JumpValid, 0);
      check("abs_hold", Jump, 12'd9);

      do_write(5, 12'hFF0, 1);
      do_lookup(5, 12'h020);
      check("rel_jump", Jump, 12'h010);
      check("rel_jv", JumpValid, 1);
      do_lookup(5, 12'h005);
      check("rel_wrap", Jump, 12'hFF5);

      // back-to-back: two consecutive pulses
      LookupReq = 1; Jptr = 5'd5; Pc = 12'h020;
      tick();
      check("b2b_jv0", JumpValid, 1);
      check("b2b_j0", Jump, 12'h010);
      Pc = 12'h100;
      tick();
      check("b2b_jv1", JumpValid, 1);
      check("b2b_j1", Jump, 12'h0F0);
      LookupReq = 0;
      tick();
      check("b2b_end", JumpValid, 0);

      do_lookup(12, 12'h300);
      check("inv_jv", JumpValid, 1);
      check("inv_jf", JumpFault, 1);
      check("inv_jump", Jump, 0);

      // same-cycle write and lookup, same index
      WrEn = 1; WrPtr = 5'd3; WrData = 12'd57; WrRel = 0;
      do_lookup(3, 12'h400);
      WrEn = 0;
      check("byp_jump", Jump, 12'd57);
      check("byp_jf", JumpFault, 0);
      check("byp_jv", JumpValid, 1);

      WrEn = 1; WrPtr = 5'd6; WrData = 12'h010; WrRel = 1;
      do_lookup(6, 12'h100);
      WrEn = 0;
      check("byp_rel", Jump, 12'h110);

      // different indices stay independent
      WrEn = 1; WrPtr = 5'd4; WrData = 12'd100; WrRel = 0;
      do_lookup(3, 12'h000);
      WrEn = 0;
      check("indep_jump", Jump, 12'd57);
      do_lookup(4, 12'h000);
      check("indep_wr4", Jump, 12'd100);
      check("indep_jf4", JumpFault, 0);

      // flush with same-cycle write and lookup
      Flush = 1; WrEn = 1; WrPtr = 5'd7; WrData = 12'd5; WrRel = 0;
      LookupReq = 1; Jptr = 5'd1;
      tick();
      idle_inputs();
      check("flush_jv", JumpValid, 0);
      check("flush_ready", Ready, 0);
      check("flush_hold", Jump, 12'd100);
      // inputs during the sweep must be dropped
      LookupReq = 1; WrEn = 1; WrPtr = 5'd7; Jptr = 5'd1;
      sweep_32("flush");
      idle_inputs();
      check("flush_jump_keep", Jump, 12'd100);
      check("flush_jf_keep", JumpFault, 0);
      do_lookup(1, 0);
      check("flush_p1_jf", JumpFault, 1);
      check("flush_p1_jump", Jump, 0);
      do_lookup(7, 0);
      check("flush_p7_jf", JumpFault, 1);
      check("flush_p7_jv", JumpValid, 1);

      // reset mid-sweep at counter 10
      do_write(2, 12'h123, 0);
      do_lookup(2, 0);
      check("pre_rst_jump", Jump, 12'h123);
      Flush = 1;
      tick();
      Flush = 0;
      for (int i = 0; i < 10; i++) tick();
      check("mid_ready", Ready, 0);
      check("mid_jump", Jump, 12'h123);
      Reset_n = 0;
      #1;
      check("mid_rst_jump", Jump, 0);
      check("mid_rst_ready", Ready, 0);
      tick();
      Reset_n = 1;
      sweep_32("rst2");
      do_lookup(2, 0);
      check("rst2_p2_jf", JumpFault, 1);
      check("rst2_p2_jump", Jump, 0);
      do_write(2, 12'h456, 0);
      do_lookup(2, 0);
      check("rst2_rewrite", Jump, 12'h456);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
